// File: rtl/cart_pkg.sv
// Shared constants and types for the MBC1 cartridge responder.
// Region bases, register targets and FSM states.
package cart_pkg;

  localparam logic [15:0] BASE_RAMEN = 16'h0000;
  localparam logic [15:0] BASE_BANK1 = 16'h2000;
  localparam logic [15:0] BASE_BANK2 = 16'h4000;
  localparam logic [15:0] BASE_MODE  = 16'h6000;
  localparam logic [15:0] BASE_RAM   = 16'hA000;

  localparam logic [3:0] RAM_EN_KEY = 4'hA;

  localparam logic [2:0] TGT_NONE  = 3'd0;
  localparam logic [2:0] TGT_RAMEN = 3'd1;
  localparam logic [2:0] TGT_BANK1 = 3'd2;
  localparam logic [2:0] TGT_BANK2 = 3'd3;
  localparam logic [2:0] TGT_MODE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cart_mbc1_map.sv
// MBC1 address decoder: bus address plus bank state to
// backing-memory address, select and register target.
module cart_mbc1_map
  import cart_pkg::*;
#(
  parameter int ROM_ADDR_W = 21,
  parameter int RAM_ADDR_W = 15
) (
  input  logic [15:0] a,
  input  logic [4:0]  bank1,
  input  logic [1:0]  bank2,
  input  logic        mode,
  input  logic        ram_en,
  output logic        hit,
  output logic        mem_sel,
  output logic [20:0] mem_addr,
  output logic [2:0]  tgt
);

  localparam logic [20:0] ROM_MASK =
    21'((64'd1 << ROM_ADDR_W) - 64'd1);
  localparam logic [20:0] RAM_MASK =
    21'((64'd1 << RAM_ADDR_W) - 64'd1);

  logic [2:0]  rgn;
  logic [20:0] rom0;
  logic [20:0] romx;
  logic [20:0] ram;

  assign rgn = a[15:13];

  always_comb begin
    rom0 = mode ? {bank2, 5'b0, a[13:0]}
                : {7'b0, a[13:0]};
    romx = {bank2, bank1, a[13:0]};
    ram  = {6'b0, (mode ? bank2 : 2'b0), a[12:0]};
    hit      = 1'b0;
    mem_sel  = 1'b0;
    mem_addr = '0;
    tgt      = TGT_NONE;
    unique case (1'b1)
      rgn == BASE_RAMEN[15:13]: begin
        hit      = 1'b1;
        mem_addr = rom0 & ROM_MASK;
        tgt      = TGT_RAMEN;
      end
      rgn == BASE_BANK1[15:13]: begin
        hit      = 1'b1;
        mem_addr = rom0 & ROM_MASK;
        tgt      = TGT_BANK1;
      end
      rgn == BASE_BANK2[15:13]: begin
        hit      = 1'b1;
        mem_addr = romx & ROM_MASK;
        tgt      = TGT_BANK2;
      end
      rgn == BASE_MODE[15:13]: begin
        hit      = 1'b1;
        mem_addr = romx & ROM_MASK;
        tgt      = TGT_MODE;
      end
      rgn == BASE_RAM[15:13]: begin
        // disabled RAM never reaches the memory port
        hit      = ram_en;
        mem_sel  = 1'b1;
        mem_addr = ram & RAM_MASK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cart_mbc1.sv
// MBC1 cartridge responder: bank registers, access edge
// detect and req/ack handshake to the backing memory.
module cart_mbc1
  import cart_pkg::*;
#(
  parameter int ROM_ADDR_W     = 21,
  parameter int RAM_ADDR_W     = 15,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        wr,
  input  logic        rd,
  input  logic        cs,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        ram_en,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLAST =
    CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        state_d;
  logic [4:0]    bank1;
  logic [1:0]    bank2;
  logic          mode;
  logic          acc;
  logic          acc_q;
  logic          drop;
  logic [CW-1:0] cnt;

  logic          start;
  logic          reg_go;
  logic          mem_go;
  logic          keep;
  logic          expire;
  logic          m_hit;
  logic          m_sel;
  logic [20:0]   m_addr;
  logic [2:0]    m_tgt;

  cart_mbc1_map #(
    .ROM_ADDR_W(ROM_ADDR_W),
    .RAM_ADDR_W(RAM_ADDR_W)
  ) u_map (
    .a        (a),
    .bank1    (bank1),
    .bank2    (bank2),
    .mode     (mode),
    .ram_en   (ram_en),
    .hit      (m_hit),
    .mem_sel  (m_sel),
    .mem_addr (m_addr),
    .tgt      (m_tgt)
  );

  assign acc    = rd | wr;
  assign start  = cs & acc & ~acc_q
                & (state == ST_IDLE);
  assign reg_go = start & wr & (m_tgt != TGT_NONE);
  assign mem_go = start & m_hit & ~reg_go;
  assign keep   = acc & ~drop;
  assign expire = (cnt == TLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (mem_go) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack)
          state_d = keep ? ST_DONE : ST_IDLE;
        else if (expire)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank1     <= 5'd1;
      bank2     <= 2'd0;
      mode      <= 1'b0;
      ram_en    <= 1'b0;
      acc_q     <= 1'b0;
      drop      <= 1'b0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dout      <= 8'hFF;
      timeout   <= 1'b0;
    end else begin
      acc_q   <= acc;
      timeout <= 1'b0;
      if (reg_go) begin
        case (m_tgt)
          TGT_RAMEN: ram_en <= (din[3:0] == RAM_EN_KEY);
          TGT_BANK1: bank1  <= (din[4:0] == 5'd0)
                               ? 5'd1 : din[4:0];
          TGT_BANK2: bank2  <= din[1:0];
          TGT_MODE:  mode   <= din[0];
          default: ;
        endcase
      end
      if (mem_go) begin
        mem_req   <= 1'b1;
        mem_we    <= wr;
        mem_sel   <= m_sel;
        mem_addr  <= m_addr;
        mem_wdata <= din;
        cnt       <= '0;
        drop      <= 1'b0;
      end
      if (state == ST_REQ) begin
        // a released access still finishes the handshake
        if (!acc) drop <= 1'b1;
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (!mem_we && keep) dout <= mem_rdata;
        end else if (expire) begin
          mem_req <= 1'b0;
          timeout <= 1'b1;
          dout    <= 8'hFF;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (state == ST_DONE && !acc) dout <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_cart_mbc1.sv
// Directed bench for cart_mbc1: banking, RAM gating,
// handshake latency, timeout, drop and async reset.
module tb_cart_mbc1;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        wr;
  logic        rd;
  logic        cs;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic [20:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        ram_en;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  cart_mbc1 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .din       (din),
    .dout      (dout),
    .wr        (wr),
    .rd        (rd),
    .cs        (cs),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ram_en    (ram_en),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [15:0] ad,
                           input logic [7:0] dat);
    a = ad; din = dat; wr = 1'b1; cs = 1'b1;
    tick();
    wr = 1'b0; cs = 1'b0;
    tick();
  endtask

  task automatic rom_read(input string tag,
                          input logic [15:0] ad,
                          input logic [7:0] rdat,
                          input logic [20:0] exp_addr);
    a = ad; rd = 1'b1; cs = 1'b1;
    tick();
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_sel"}, mem_sel, 0);
    mem_ack = 1'b1; mem_rdata = rdat;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_dout"}, dout, rdat);
    chk({tag, "_reqlo"}, mem_req, 0);
    rd = 1'b0; cs = 1'b0;
    tick();
    chk({tag, "_ff"}, dout, 8'hFF);
    tick();
  endtask

  initial begin
    rst = 1'b0; a = '0; din = '0; wr = 1'b0;
    rd = 1'b0; cs = 1'b0; mem_rdata = '0;
    mem_ack = 1'b0;
    tick(); tick();
    chk("rst_dout", dout, 8'hFF);
    chk("rst_req", mem_req, 0);
    chk("rst_ramen", ram_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_to", timeout, 0);
    rst = 1'b1;
    tick();

    rom_read("rd4123", 16'h4123, 8'h5A, 21'h004123);

    reg_write(16'h2000, 8'h00);
    rom_read("bank0", 16'h4000, 8'h11, 21'h004000);
    reg_write(16'h2000, 8'h1F);
    reg_write(16'h4000, 8'h03);
    rom_read("rd7fff", 16'h7FFF, 8'h22, 21'h1FFFFF);

    reg_write(16'h4000, 8'h02);
    reg_write(16'h6000, 8'h01);
    rom_read("mode1", 16'h0010, 8'h33, 21'h100010);
    reg_write(16'h6000, 8'h00);
    rom_read("mode0", 16'h0010, 8'h44, 21'h000010);

    a = 16'hA000; rd = 1'b1; cs = 1'b1;
    tick();
    chk("ramoff_req", mem_req, 0);
    tick();
    chk("ramoff_req2", mem_req, 0);
    chk("ramoff_dout", dout, 8'hFF);
    rd = 1'b0; cs = 1'b0;
    tick();

    reg_write(16'h0000, 8'h0A);
    chk("ramen_on", ram_en, 1);
    a = 16'hA005; din = 8'h77; wr = 1'b1; cs = 1'b1;
    tick();
    chk("ramwr_req", mem_req, 1);
    chk("ramwr_sel", mem_sel, 1);
    chk("ramwr_we", mem_we, 1);
    chk("ramwr_addr", mem_addr, 21'h000005);
    chk("ramwr_data", mem_wdata, 8'h77);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ramwr_reqlo", mem_req, 0);
    wr = 1'b0; cs = 1'b0;
    tick(); tick();

    reg_write(16'h6000, 8'h01);
    a = 16'hA123; rd = 1'b1; cs = 1'b1;
    tick();
    chk("ramrd_sel", mem_sel, 1);
    chk("ramrd_addr", mem_addr, 21'h004123);
    mem_ack = 1'b1; mem_rdata = 8'h9C;
    tick();
    mem_ack = 1'b0;
    chk("ramrd_dout", dout, 8'h9C);
    rd = 1'b0; cs = 1'b0;
    tick(); tick();
    reg_write(16'h6000, 8'h00);

    a = 16'h4000; rd = 1'b1; cs = 1'b1;
    tick();
    chk("to_req0", mem_req, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_req", mem_req, 1);
      chk("to_nopulse", timeout, 0);
    end
    tick();
    chk("to_reqlo", mem_req, 0);
    chk("to_pulse", timeout, 1);
    chk("to_dout", dout, 8'hFF);
    tick();
    chk("to_pulse_end", timeout, 0);
    rd = 1'b0; cs = 1'b0;
    tick(); tick();

    a = 16'h4100; rd = 1'b1; cs = 1'b1;
    tick();
    chk("drop_req", mem_req, 1);
    rd = 1'b0; cs = 1'b0;
    tick(); tick();
    chk("drop_hold", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'hAA;
    tick();
    mem_ack = 1'b0;
    chk("drop_reqlo", mem_req, 0);
    chk("drop_dout", dout, 8'hFF);
    tick();
    chk("drop_dout2", dout, 8'hFF);
    rom_read("after_drop", 16'h4001, 8'h66, 21'h17C001);

    a = 16'h4000; rd = 1'b1; cs = 1'b1;
    tick();
    chk("arst_req", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_reqlo", mem_req, 0);
    chk("arst_ramen", ram_en, 0);
    chk("arst_dout", dout, 8'hFF);
    rd = 1'b0; cs = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rom_read("arst_bank", 16'h4000, 8'h5B, 21'h004000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_mbc1.md
Name: cart_mbc1

Overview:
Cartridge-side responder for the Game Boy external cartridge bus that the `boy` top level drives: a, dout, din, wr, rd, cs. It implements an MBC1-style memory bank controller with bank and mode registers. It translates bus accesses into req/ack transactions on a backing ROM/RAM memory port and returns read data on the bus. It sits outside `boy`, in the board wrapper, in place of a physical cartridge.

Parameters:
ROM_ADDR_W, 21, backing ROM byte-address width (2 MiB max); upper bank bits masked to this width.
RAM_ADDR_W, 15, backing external-RAM byte-address width (32 KiB max).
TIMEOUT_CYCLES, 8, max clk cycles mem_req may wait for mem_ack before abort.

Ports:
clk  in  1  system clock (4.19 MHz domain, same as boy).
rst  in  1  asynchronous, active-low reset (asserted when 0).
a  in  16  cartridge address bus from boy.
din  in  8  write data from boy (boy dout).
dout  out  8  read data to boy (boy din).
wr  in  1  write enable, level, held for the whole access.
rd  in  1  read enable, level, held for the whole access.
cs  in  1  chip select (wr|rd); used only as an access qualifier.
mem_req  out  1  backing-memory request, held until mem_ack.
mem_we  out  1  1 = write, 0 = read; stable while mem_req.
mem_sel  out  1  0 = ROM, 1 = RAM; stable while mem_req.
mem_addr  out  21  byte address, zero-extended for RAM.
mem_wdata  out  8  write data; stable while mem_req.
mem_rdata  in  8  read data, valid in the mem_ack cycle.
mem_ack  in  1  single-cycle completion strobe.
ram_en  out  1  external-RAM enable register state.
timeout  out  1  one-cycle pulse when a transaction is aborted.

Behaviour:
- Reset (rst=0, async): state IDLE, bank1=5'd1, bank2=2'd0, mode=0, ram_en=0, mem_req=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, dout=8'hFF, timeout=0.
- Access start:
  - Rising edge of (rd|wr) detected against a registered previous value, qualified by cs.
  - a and din are latched at the start.
  - If wr and rd are both high, the access is a write.
- Register writes (no memory transaction); each takes effect the cycle after the start:
  - 0000-1FFF: ram_en <= (din[3:0]==4'hA).
  - 2000-3FFF: bank1 <= din[4:0]; a value of 0 is stored as 1.
  - 4000-5FFF: bank2 <= din[1:0].
  - 6000-7FFF: mode <= din[0].
- Address translation (registered at start):
  - Read 0000-3FFF: mem_addr = mode ? {bank2,5'b0,a[13:0]} : {7'b0,a[13:0]}.
  - Read 4000-7FFF: mem_addr = {bank2,bank1,a[13:0]}.
  - ROM addresses are masked to ROM_ADDR_W.
  - A000-BFFF read/write: mem_sel=1, mem_addr = {mode?bank2:2'b0, a[12:0]}, masked to RAM_ADDR_W.
  - A000-BFFF with ram_en=0: no transaction; reads return FF; writes are dropped.
  - Any other address: ignored; dout stays FF.
- FSM IDLE -> REQ -> DONE -> IDLE:
  - IDLE: on a valid memory access start, assert mem_req the next cycle and go to REQ.
  - REQ: hold mem_req and all mem_* outputs stable. On mem_ack, deassert mem_req the next cycle. For a read, capture mem_rdata into dout, visible the cycle after the ack. Go to DONE.
  - REQ timeout: after TIMEOUT_CYCLES cycles without ack, drop mem_req, pulse timeout, force dout=FF, go to DONE.
  - DONE: hold dout until rd and wr are both low, then set dout=FF and return to IDLE.
  - rd/wr deasserting mid-REQ: the handshake still completes (mem_req is never withdrawn before ack or timeout); the read data is discarded and the FSM returns to IDLE.
  - A new rd/wr rising edge during REQ/DONE is ignored.
- Best-case read latency: rd edge sampled at cycle N, mem_req at N+1, ack at N+1, dout valid at N+2.
- mem_ack while in IDLE or DONE is ignored.

Decomposition:
- Package cart_pkg:
  - Region base constants: 16'h0000, 16'h2000, 16'h4000, 16'h6000, 16'hA000.
  - RAM_EN_KEY = 4'hA.
  - FSM state encoding: IDLE, REQ, DONE.
- Sub-module cart_mbc1_map: combinational {a, bank1, bank2, mode, ram_en} -> {hit, mem_sel, mem_addr, reg_write_target}.
- The top level holds the registers, edge detect and FSM.

Test Plan:
- Reset, then read 0x4123 with ack at latency 1, mem_rdata=8'h5A -> mem_addr=21'h004123, mem_sel=0; dout=8'h5A two cycles after the rd edge; dout returns to FF after rd falls.
- Write 0x2000 with 8'h00, then 8'h1F; write 0x4000 with 8'h03; read 0x7FFF -> first write stores bank1=1; mem_addr=21'h1FFFFF after the 1F write.
- Write 0x6000=1, read 0x0010 with bank2=2 -> mem_addr=21'h100010. Then mode=0 -> mem_addr=21'h000010.
- Read 0xA000 with ram_en=0 -> no mem_req, dout=FF. Write 0x0000=8'h0A, then write 0xA005=8'h77 -> mem_sel=1, mem_we=1, mem_addr=5, mem_wdata=8'h77.
- Read with mem_ack withheld -> mem_req high for exactly 8 cycles, then a one-cycle timeout pulse and dout=FF. Separately, drop rd mid-REQ and ack late -> no dout change; next access proceeds normally.
- rst=0 asynchronously during REQ -> mem_req low immediately. After release, bank1=1, ram_en=0, dout=FF.
